// File: rtl/dbg_bridge_fifo_v2.sv
`default_nettype none
// ============================================================================
// Module   : dbg_bridge_fifo_v2
// Purpose  : First-word-fall-through FIFO with occupancy, thresholds and sticky errors.
// Revision : 2.0
// ============================================================================
module dbg_bridge_fifo_v2 #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 4,
    parameter int ADDR_W     = 2,
    parameter int AFULL_LVL  = 3,
    parameter int AEMPTY_LVL = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [WIDTH-1:0]  data_in_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              flush_i,
    input  logic              clr_err_i,
    output logic [WIDTH-1:0]  data_out_o,
    output logic              accept_o,
    output logic              valid_o,
    output logic [ADDR_W:0]   level_o,
    output logic              afull_o,
    output logic              aempty_o,
    output logic              overflow_o,
    output logic              underflow_o
);

    localparam logic [ADDR_W:0]   c_DEPTH   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   c_CNT_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   c_AFULL   = (ADDR_W+1)'(AFULL_LVL);
    localparam logic [ADDR_W:0]   c_AEMPTY  = (ADDR_W+1)'(AEMPTY_LVL);
    localparam logic [ADDR_W-1:0] c_LAST    = ADDR_W'(DEPTH-1);
    localparam logic [ADDR_W-1:0] c_PTR_ONE = ADDR_W'(1);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_accept;
    logic              w_valid;
    logic              w_wr_en;
    logic              w_rd_en;
    logic              w_set_ovf;
    logic              w_set_unf;
    logic [ADDR_W-1:0] w_wr_ptr_nxt;
    logic [ADDR_W-1:0] w_rd_ptr_nxt;
    logic [ADDR_W:0]   w_count_nxt;

    // Handshake flags come only from the registered count: no bypass paths.
    assign w_accept  = (r_count != c_DEPTH);
    assign w_valid   = (r_count != '0);
    assign w_wr_en   = push_i & w_accept & ~flush_i;
    assign w_rd_en   = pop_i  & w_valid  & ~flush_i;
    assign w_set_ovf = push_i & ~w_accept & ~flush_i;
    assign w_set_unf = pop_i  & ~w_valid  & ~flush_i;

    // Explicit wrap so non-power-of-two depths never index past the last entry.
    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_count_nxt  = r_count;
        if (w_wr_en) begin
            w_wr_ptr_nxt = (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + c_PTR_ONE;
        end
        if (w_rd_en) begin
            w_rd_ptr_nxt = (r_rd_ptr == c_LAST) ? '0 : r_rd_ptr + c_PTR_ONE;
        end
        if (w_wr_en && !w_rd_en) begin
            w_count_nxt = r_count + c_CNT_ONE;
        end else if (w_rd_en && !w_wr_en) begin
            w_count_nxt = r_count - c_CNT_ONE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
        end
    end

    // A new error event in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_set_ovf) begin
                r_overflow <= 1'b1;
            end else if (clr_err_i) begin
                r_overflow <= 1'b0;
            end
            if (w_set_unf) begin
                r_underflow <= 1'b1;
            end else if (clr_err_i) begin
                r_underflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= data_in_i;
        end
    end

    assign data_out_o  = r_mem[r_rd_ptr];
    assign accept_o    = w_accept;
    assign valid_o     = w_valid;
    assign level_o     = r_count;
    assign afull_o     = (r_count >= c_AFULL);
    assign aempty_o    = (r_count <= c_AEMPTY);
    assign overflow_o  = r_overflow;
    assign underflow_o = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_dbg_bridge_fifo_v2.sv
`default_nettype none
// ============================================================================
// Module   : tb_dbg_bridge_fifo_v2
// Purpose  : Directed self-checking bench for dbg_bridge_fifo_v2 (DEPTH 4 and DEPTH 3).
// Revision : 2.0
// ============================================================================
module tb_dbg_bridge_fifo_v2;

    logic       clk;
    logic       rst;
    int         n_checks;
    int         n_fail;

    // DEPTH=4 instance
    logic [7:0] din;
    logic       push, pop, flush, clr;
    logic [7:0] dout;
    logic       accept, valid, afull, aempty, ovf, unf;
    logic [2:0] level;

    // DEPTH=3 instance
    logic [7:0] din3;
    logic       push3, pop3;
    logic [7:0] dout3;
    logic       accept3, valid3, afull3, aempty3, ovf3, unf3;
    logic [2:0] level3;

    dbg_bridge_fifo_v2 #(
        .WIDTH(8), .DEPTH(4), .ADDR_W(2), .AFULL_LVL(3), .AEMPTY_LVL(1)
    ) u_dut4 (
        .clk_i(clk), .rst_i(rst), .data_in_i(din), .push_i(push), .pop_i(pop),
        .flush_i(flush), .clr_err_i(clr), .data_out_o(dout), .accept_o(accept),
        .valid_o(valid), .level_o(level), .afull_o(afull), .aempty_o(aempty),
        .overflow_o(ovf), .underflow_o(unf)
    );

    dbg_bridge_fifo_v2 #(
        .WIDTH(8), .DEPTH(3), .ADDR_W(2), .AFULL_LVL(2), .AEMPTY_LVL(1)
    ) u_dut3 (
        .clk_i(clk), .rst_i(rst), .data_in_i(din3), .push_i(push3), .pop_i(pop3),
        .flush_i(1'b0), .clr_err_i(1'b0), .data_out_o(dout3), .accept_o(accept3),
        .valid_o(valid3), .level_o(level3), .afull_o(afull3), .aempty_o(aempty3),
        .overflow_o(ovf3), .underflow_o(unf3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        push = 1'b0; pop = 1'b0; flush = 1'b0; clr = 1'b0; din = 8'h00;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        push3 = 1'b0; pop3 = 1'b0; din3 = 8'h00;
        #12;
        n_checks++;
        if ({valid, accept, level, afull, aempty, ovf, unf} !== {1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state4: got v=%b a=%b l=%0d af=%b ae=%b o=%b u=%b required 0 1 0 0 1 0 0",
                     valid, accept, level, afull, aempty, ovf, unf);
        end
        n_checks++;
        if ({valid3, accept3, level3, aempty3} !== {1'b0, 1'b1, 3'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_state3: got v=%b a=%b l=%0d ae=%b required 0 1 0 1",
                     valid3, accept3, level3, aempty3);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_fill();
        logic [7:0] exp_lvl_flags [4];
        exp_lvl_flags[0] = 8'b0_1_1_0;   // {accept, aempty, afull} packed loosely below
        for (int i = 0; i < 4; i++) begin
            din = 8'hA1 + 8'(i); push = 1'b1;
            tick();
            n_checks++;
            if (level !== 3'(i + 1) || dout !== 8'hA1 || valid !== 1'b1) begin
                n_fail++;
                $display("FAIL fill_push%0d: got level=%0d dout=%h valid=%b required level=%0d dout=a1 valid=1",
                         i, level, dout, valid, i + 1);
            end
            n_checks++;
            if (afull !== (i >= 2) || aempty !== (i == 0) || accept !== (i != 3)) begin
                n_fail++;
                $display("FAIL fill_flags%0d: got afull=%b aempty=%b accept=%b required %b %b %b",
                         i, afull, aempty, accept, (i >= 2), (i == 0), (i != 3));
            end
        end
        din = 8'hA5; push = 1'b1;
        tick();
        n_checks++;
        if (ovf !== 1'b1 || level !== 3'd4 || dout !== 8'hA1) begin
            n_fail++;
            $display("FAIL fill_overflow: got ovf=%b level=%0d dout=%h required ovf=1 level=4 dout=a1",
                     ovf, level, dout);
        end
        push = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (dout !== 8'hA1 + 8'(i) || valid !== 1'b1) begin
                n_fail++;
                $display("FAIL fill_pop%0d: got dout=%h valid=%b required dout=%h valid=1",
                         i, dout, valid, 8'hA1 + 8'(i));
            end
            pop = 1'b1;
            tick();
            pop = 1'b0;
        end
        n_checks++;
        if (valid !== 1'b0 || level !== 3'd0 || unf !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_drained: got valid=%b level=%0d unf=%b required 0 0 0", valid, level, unf);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_checks++;
        if (ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_clr_ovf: got ovf=%b required 0", ovf);
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 4; i++) begin
            din = 8'h10 + 8'(i); push = 1'b1;
            tick();
        end
        din = 8'h55; push = 1'b1; pop = 1'b1;
        tick();
        idle();
        n_checks++;
        if (level !== 3'd3 || ovf !== 1'b1 || dout !== 8'h11 || unf !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_full: got level=%0d ovf=%b dout=%h unf=%b required level=3 ovf=1 dout=11 unf=0",
                     level, ovf, dout, unf);
        end
        flush = 1'b1; clr = 1'b1;
        tick();
        idle();
        din = 8'h66; push = 1'b1; pop = 1'b1;
        tick();
        idle();
        n_checks++;
        if (level !== 3'd1 || unf !== 1'b1 || ovf !== 1'b0 || dout !== 8'h66 || valid !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_empty: got level=%0d unf=%b ovf=%b dout=%h valid=%b required 1 1 0 66 1",
                     level, unf, ovf, dout, valid);
        end
        pop = 1'b1;
        tick();
        idle();
        clr = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_flush();
        pop = 1'b1;
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            din = 8'h21 + 8'(i); push = 1'b1;
            tick();
        end
        n_checks++;
        if (level !== 3'd3 || unf !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_pre: got level=%0d unf=%b required level=3 unf=1", level, unf);
        end
        din = 8'h99; push = 1'b1; flush = 1'b1;
        tick();
        idle();
        n_checks++;
        if (level !== 3'd0 || valid !== 1'b0 || unf !== 1'b1 || ovf !== 1'b0 || accept !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_empty: got level=%0d valid=%b unf=%b ovf=%b accept=%b required 0 0 1 0 1",
                     level, valid, unf, ovf, accept);
        end
        din = 8'h31; push = 1'b1;
        tick();
        idle();
        n_checks++;
        if (level !== 3'd1 || dout !== 8'h31) begin
            n_fail++;
            $display("FAIL flush_refill: got level=%0d dout=%h required level=1 dout=31", level, dout);
        end
        pop = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_errors();
        clr = 1'b1;
        tick();
        idle();
        pop = 1'b1;
        tick();
        idle();
        n_checks++;
        if (unf !== 1'b1) begin
            n_fail++;
            $display("FAIL err_set: got unf=%b required 1", unf);
        end
        clr = 1'b1;
        tick();
        idle();
        n_checks++;
        if (unf !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clear: got unf=%b required 0", unf);
        end
        pop = 1'b1;
        tick();
        clr = 1'b1;
        tick();
        idle();
        n_checks++;
        if (unf !== 1'b1) begin
            n_fail++;
            $display("FAIL err_set_wins: got unf=%b required 1", unf);
        end
        clr = 1'b1;
        tick();
        idle();
        n_checks++;
        if (unf !== 1'b0 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL err_final_clear: got unf=%b ovf=%b required 0 0", unf, ovf);
        end
    endtask

    task automatic test_wrap();
        din3 = 8'hEE; push3 = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            logic [7:0] exp_out;
            exp_out = (i == 0) ? 8'hEE : 8'(i - 1);
            n_checks++;
            if (dout3 !== exp_out || level3 !== 3'd1) begin
                n_fail++;
                $display("FAIL wrap_pair%0d: got dout=%h level=%0d required dout=%h level=1",
                         i, dout3, level3, exp_out);
            end
            din3 = 8'(i); push3 = 1'b1; pop3 = 1'b1;
            tick();
        end
        push3 = 1'b0; pop3 = 1'b0;
        n_checks++;
        if (dout3 !== 8'h09 || level3 !== 3'd1 || ovf3 !== 1'b0 || unf3 !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_last: got dout=%h level=%0d ovf=%b unf=%b required 09 1 0 0",
                     dout3, level3, ovf3, unf3);
        end
        pop3 = 1'b1;
        tick();
        pop3 = 1'b0;
        n_checks++;
        if (valid3 !== 1'b0 || level3 !== 3'd0) begin
            n_fail++;
            $display("FAIL wrap_drained: got valid=%b level=%0d required 0 0", valid3, level3);
        end
        for (int i = 0; i < 3; i++) begin
            din3 = 8'hC0 + 8'(i); push3 = 1'b1;
            tick();
        end
        push3 = 1'b0;
        n_checks++;
        if (accept3 !== 1'b0 || level3 !== 3'd3 || afull3 !== 1'b1 || dout3 !== 8'hC0) begin
            n_fail++;
            $display("FAIL wrap_full3: got accept=%b level=%0d afull=%b dout=%h required 0 3 1 c0",
                     accept3, level3, afull3, dout3);
        end
    endtask

    task automatic test_async_reset();
        pop = 1'b1;
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            din = 8'h40 + 8'(i); push = 1'b1;
            tick();
        end
        idle();
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({valid, accept, level, afull, aempty, ovf, unf} !== {1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset4: got v=%b a=%b l=%0d af=%b ae=%b o=%b u=%b required 0 1 0 0 1 0 0",
                     valid, accept, level, afull, aempty, ovf, unf);
        end
        n_checks++;
        if (valid3 !== 1'b0 || level3 !== 3'd0 || accept3 !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset3: got valid=%b level=%0d accept=%b required 0 0 1",
                     valid3, level3, accept3);
        end
        @(negedge clk);
        rst = 1'b0;
        din = 8'h77; push = 1'b1;
        tick();
        idle();
        n_checks++;
        if (level !== 3'd1 || dout !== 8'h77) begin
            n_fail++;
            $display("FAIL async_after: got level=%0d dout=%h required level=1 dout=77", level, dout);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_fill();
        test_simultaneous();
        test_flush();
        test_errors();
        test_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
